// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg
//   Shared types and helpers for the frame-aware AXI4-Stream arbiter.
//   - arb_state_e : arbiter FSM states (ST_IDLE, ST_XFER)
//   - rr_pick_t   : result of a round-robin search (valid + index)
//   - rr_select() : first set request bit at or after a pointer, wrapping
//                   modulo n (n <= RR_MAX)
package axis_arb_pkg;

    localparam int RR_MAX = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } rr_pick_t;

    // Searches req[ptr], req[ptr+1], ... wrapping from n-1 back to 0, so
    // non-power-of-two port counts wrap at n rather than at the bit width.
    function automatic rr_pick_t rr_select(input logic [RR_MAX-1:0] req,
                                           input logic [3:0]        ptr,
                                           input int                n);
        rr_pick_t pick;
        int       j;
        pick = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if ((i < n) && !pick.valid && req[j[3:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = j[3:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_rr_select.sv
// arb_rr_select
//   Combinational round-robin picker.
//   Ports:
//     req   [N-1:0]     in  - request vector
//     ptr   [IDX_W-1:0] in  - search start position (highest current priority)
//     idx   [IDX_W-1:0] out - first requester at or after ptr, wrapping
//     valid             out - at least one request present
module arb_rr_select
    import axis_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_select(RR_MAX'(req), 4'(ptr), N);
        idx   = IDX_W'(pick.idx);
        valid = pick.valid;
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
//   Frame-aware round-robin arbiter merging S_COUNT AXI4-Stream sources into
//   one sink. A grant is held from the first beat through the tlast beat, so
//   frames never interleave. Output is one registered stage.
//   Optional feature macro: AXIS_FRAME_ARB_PRIORITY_EN adds s_prio; when any
//   requester is high priority, only high-priority requesters are searched.
//   Ports:
//     clk, rst_n                   clock (rising), async active-low reset
//     s_axis_t*                    per-port inputs, port i at slice i
//     s_axis_tready [S_COUNT]      only the granted port may see ready
//     m_axis_t*                    merged registered output stream
//     grant_valid                  a frame is granted (FSM is in ST_XFER)
//     grant_index                  index of the granted port
//     s_prio [S_COUNT]             (macro only) high-priority request flags
//   Handshake: a beat moves when tvalid && tready are both high on a rising
//   edge; tready depends only on m_axis_tready and the output-valid flop,
//   never on any s_axis_tvalid.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int USER_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
`ifdef AXIS_FRAME_ARB_PRIORITY_EN
    input  logic [S_COUNT-1:0]               s_prio,
`endif
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [S_COUNT-1:0]               s_axis_tvalid,
    output logic [S_COUNT-1:0]               s_axis_tready,
    input  logic [S_COUNT-1:0]               s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic                             grant_valid,
    output logic [$clog2(S_COUNT)-1:0]       grant_index
);

    localparam int IDX_W = $clog2(S_COUNT);

    arb_state_e              state_q, state_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]        grant_index_q, grant_index_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0]   m_tkeep_q, m_tkeep_d;
    logic                    m_tlast_q, m_tlast_d;
    logic [USER_WIDTH-1:0]   m_tuser_q, m_tuser_d;

    logic [S_COUNT-1:0]      arb_req;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_valid;

    logic [DATA_WIDTH-1:0]   sel_tdata;
    logic [KEEP_WIDTH-1:0]   sel_tkeep;
    logic                    sel_tvalid;
    logic                    sel_tlast;
    logic [USER_WIDTH-1:0]   sel_tuser;
    logic                    tready_en;
    logic                    accept;

    // Request mask: with priority enabled, high-priority requesters hide the
    // rest; rr_ptr is shared so fairness holds within whichever class wins.
`ifdef AXIS_FRAME_ARB_PRIORITY_EN
    always_comb begin
        arb_req = s_axis_tvalid;
        if (|(s_axis_tvalid & s_prio)) arb_req = s_axis_tvalid & s_prio;
    end
`else
    assign arb_req = s_axis_tvalid;
`endif

    arb_rr_select #(
        .N     (S_COUNT),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Input slice mux for the granted port.
    assign sel_tdata  = s_axis_tdata[grant_index_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_tkeep  = s_axis_tkeep[grant_index_q*KEEP_WIDTH +: KEEP_WIDTH];
    assign sel_tvalid = s_axis_tvalid[grant_index_q];
    assign sel_tlast  = s_axis_tlast[grant_index_q];
    assign sel_tuser  = s_axis_tuser[grant_index_q*USER_WIDTH +: USER_WIDTH];

    // Output register can take a beat when empty or draining this cycle.
    assign tready_en = m_axis_tready || !m_tvalid_q;
    assign accept    = (state_q == ST_XFER) && sel_tvalid && tready_en;

    always_comb begin
        s_axis_tready = '0;
        if (state_q == ST_XFER) s_axis_tready[grant_index_q] = tready_en;
    end

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_index_d = grant_index_q;
        rr_ptr_d      = rr_ptr_q;
        m_tvalid_d    = m_tvalid_q;
        m_tdata_d     = m_tdata_q;
        m_tkeep_d     = m_tkeep_q;
        m_tlast_d     = m_tlast_q;
        m_tuser_d     = m_tuser_q;

        if (m_axis_tready) m_tvalid_d = 1'b0;
        if (accept) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = sel_tdata;
            m_tkeep_d  = sel_tkeep;
            m_tlast_d  = sel_tlast;
            m_tuser_d  = sel_tuser;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_index_d = pick_idx;
                    grant_valid_d = 1'b1;
                    state_d       = ST_XFER;
                end
            end
            ST_XFER: begin
                // Grant is released only by an accepted tlast beat; a source
                // that stalls mid-frame keeps the grant.
                if (accept && sel_tlast) begin
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                    if (grant_index_q == IDX_W'(S_COUNT - 1)) rr_ptr_d = '0;
                    else rr_ptr_d = grant_index_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            rr_ptr_q      <= '0;
            m_tvalid_q    <= 1'b0;
            m_tdata_q     <= '0;
            m_tkeep_q     <= '0;
            m_tlast_q     <= 1'b0;
            m_tuser_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
            rr_ptr_q      <= rr_ptr_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tdata_q     <= m_tdata_d;
            m_tkeep_q     <= m_tkeep_d;
            m_tlast_q     <= m_tlast_d;
            m_tuser_q     <= m_tuser_d;
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? m_tkeep_q : {KEEP_WIDTH{1'b1}};
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tuser  = m_tuser_q;
    assign grant_valid   = grant_valid_q;
    assign grant_index   = grant_index_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter
//   Directed bench for axis_frame_arbiter (S_COUNT=4, DATA_WIDTH=8):
//   single-source frame, round-robin fairness, output backpressure, source
//   stall, reset mid-frame and (with AXIS_FRAME_ARB_PRIORITY_EN) priority.
module tb_axis_frame_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  p_data [4];
    logic [3:0]  p_valid;
    logic [3:0]  p_last;
    logic [3:0]  p_user;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic [3:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic [0:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        grant_valid;
    logic [1:0]  grant_index;
`ifdef AXIS_FRAME_ARB_PRIORITY_EN
    logic [3:0]  s_prio;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_beat;
    logic [3:0] cnt [4];
    logic [3:0] acc;
    logic       done;

    assign s_axis_tdata = {p_data[3], p_data[2], p_data[1], p_data[0]};
    assign s_axis_tkeep = 4'hf;

    axis_frame_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef AXIS_FRAME_ARB_PRIORITY_EN
        .s_prio        (s_prio),
`endif
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (p_valid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (p_last),
        .s_axis_tuser  (p_user),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .grant_valid   (grant_valid),
        .grant_index   (grant_index)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
        p_valid[p] = v;
        p_data[p]  = d;
        p_last[p]  = l;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        p_valid       = '0;
        p_last        = '0;
        p_user        = '0;
        m_axis_tready = 1'b1;
        done          = 1'b0;
        for (int p = 0; p < 4; p++) begin
            p_data[p] = '0;
            cnt[p]    = '0;
        end
`ifdef AXIS_FRAME_ARB_PRIORITY_EN
        s_prio = '0;
`endif

        // Reset state
        #3;
        check("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_index", 32'(grant_index), 0);
        check("rst_s_tready", 32'(s_axis_tready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source: port 2 sends 0x11, 0x22, 0x33
        tick();
        drive(2, 1'b1, 8'h11, 1'b0);
        #1;
        check("t1_idle_tready", 32'(s_axis_tready), 0);
        check("t1_idle_gvalid", 32'(grant_valid), 0);
        tick();
        #1;
        check("t1_gvalid", 32'(grant_valid), 1);
        check("t1_gindex", 32'(grant_index), 2);
        check("t1_tready", 32'(s_axis_tready), 32'h4);
        check("t1_mvalid0", 32'(m_axis_tvalid), 0);
        tick();
        drive(2, 1'b1, 8'h22, 1'b0);
        #1;
        check("t1_mvalid1", 32'(m_axis_tvalid), 1);
        check("t1_beat1", 32'({m_axis_tlast, m_axis_tdata}), 32'h011);
        tick();
        drive(2, 1'b1, 8'h33, 1'b1);
        #1;
        check("t1_beat2", 32'({m_axis_tlast, m_axis_tdata}), 32'h022);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0);
        drive(0, 1'b1, 8'h44, 1'b1);
        #1;
        check("t1_beat3", 32'({m_axis_tlast, m_axis_tdata}), 32'h133);
        check("t1_bubble_gvalid", 32'(grant_valid), 0);
        check("t1_bubble_tready", 32'(s_axis_tready), 0);
        tick();
        #1;
        check("t1_next_gindex", 32'(grant_index), 0);
        check("t1_next_mvalid", 32'(m_axis_tvalid), 0);
        check("t1_next_tready", 32'(s_axis_tready), 32'h1);
        tick();
        drive(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("t1_single_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'h144);
        check("t1_single_gvalid", 32'(grant_valid), 0);
        tick();
        #1;
        check("t1_drain_mvalid", 32'(m_axis_tvalid), 0);

        // Reset mid-frame: port 3 frame interrupted during beat 2 (rr_ptr is 1)
        drive(3, 1'b1, 8'hA1, 1'b0);
        tick();
        #1;
        check("rs_gindex", 32'(grant_index), 3);
        tick();
        drive(3, 1'b1, 8'hA2, 1'b0);
        #1;
        check("rs_beat1", 32'(m_axis_tdata), 32'hA1);
        rst_n = 1'b0;
        #1;
        check("rs_mvalid", 32'(m_axis_tvalid), 0);
        check("rs_gvalid", 32'(grant_valid), 0);
        check("rs_tready", 32'(s_axis_tready), 0);
        drive(3, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: all ports request 2-beat frames continuously
        for (int p = 0; p < 4; p++) begin
            cnt[p] = 4'd1;
            drive(p, 1'b1, {4'(p), 4'd1}, 1'b0);
        end
        exp_q = {9'h001, 9'h102, 9'h011, 9'h112, 9'h021, 9'h122,
                 9'h031, 9'h132, 9'h003, 9'h104};
        #1;
        tick();
        #1;
        check("rs_first_grant", 32'(grant_index), 0);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            acc = p_valid & s_axis_tready;
            tick();
            for (int p = 0; p < 4; p++) begin
                if (acc[p]) begin
                    cnt[p] = cnt[p] + 4'd1;
                    drive(p, 1'b1, {4'(p), cnt[p]}, ~cnt[p][0]);
                end
            end
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                exp_beat = exp_q.pop_front();
                check("fair_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_beat));
                if (exp_q.size() == 0) begin
                    done = 1'b1;
                    for (int p = 0; p < 4; p++) drive(p, 1'b0, 8'h00, 1'b0);
                end
            end
        end
        if (!done) check("fair_timeout", 32'(exp_q.size()), 0);

        // Backpressure: port 1 (rr_ptr is 1), stall output 5 cycles
        p_user[1] = 1'b1;
        drive(1, 1'b1, 8'hB1, 1'b0);
        tick();
        #1;
        check("bp_gindex", 32'(grant_index), 1);
        tick();
        m_axis_tready = 1'b0;
        drive(1, 1'b1, 8'hB2, 1'b0);
        #1;
        check("bp_beat1", 32'(m_axis_tdata), 32'hB1);
        check("bp_tuser", 32'(m_axis_tuser), 1);
        check("bp_tready_stall", 32'(s_axis_tready), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            check("bp_hold_valid", 32'(m_axis_tvalid), 1);
            check("bp_hold_data", 32'(m_axis_tdata), 32'hB1);
            check("bp_hold_tready", 32'(s_axis_tready), 0);
        end
        m_axis_tready = 1'b1;
        #1;
        check("bp_release_tready", 32'(s_axis_tready), 32'h2);
        tick();
        p_user[1] = 1'b0;
        drive(1, 1'b1, 8'hB3, 1'b1);
        #1;
        check("bp_beat2", 32'({m_axis_tlast, m_axis_tdata}), 32'h0B2);
        tick();
        drive(1, 1'b0, 8'h00, 1'b0);
        #1;
        check("bp_beat3", 32'({m_axis_tlast, m_axis_tuser, m_axis_tdata}), 32'h2B3);
        tick();
        #1;
        check("bp_no_dup", 32'(m_axis_tvalid), 0);

        // Source stall: port 2 granted (rr_ptr is 2), drops tvalid while port 1 waits
        drive(2, 1'b1, 8'hC1, 1'b0);
        tick();
        drive(1, 1'b1, 8'hD1, 1'b1);
        #1;
        check("st_gindex", 32'(grant_index), 2);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0);
        #1;
        check("st_beat1", 32'(m_axis_tdata), 32'hC1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("st_hold_gvalid", 32'(grant_valid), 1);
            check("st_hold_gindex", 32'(grant_index), 2);
            check("st_hold_tready", 32'(s_axis_tready), 32'h4);
        end
        drive(2, 1'b1, 8'hC2, 1'b1);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0);
        #1;
        check("st_beat2", 32'({m_axis_tlast, m_axis_tdata}), 32'h1C2);
        check("st_release", 32'(grant_valid), 0);
        tick();
        #1;
        check("st_next_gindex", 32'(grant_index), 1);
        check("st_next_gvalid", 32'(grant_valid), 1);
        tick();
        drive(1, 1'b0, 8'h00, 1'b0);
        #1;
        check("st_port1_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'h1D1);
        tick();

`ifdef AXIS_FRAME_ARB_PRIORITY_EN
        // Priority: ports 0 and 3 request, port 3 high priority, rr_ptr reset to 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s_prio = 4'b1000;
        drive(0, 1'b1, 8'hE0, 1'b1);
        drive(3, 1'b1, 8'hE3, 1'b1);
        #1;
        tick();
        #1;
        check("pr_first", 32'(grant_index), 3);
        tick();
        drive(3, 1'b0, 8'h00, 1'b0);
        #1;
        check("pr_beat3", 32'(m_axis_tdata), 32'hE3);
        tick();
        #1;
        check("pr_second", 32'(grant_index), 0);
        tick();
        drive(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("pr_beat0", 32'(m_axis_tdata), 32'hE0);
        tick();
`endif

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
